// File: rtl/cla_seq_adder_ctrl.sv
// Byte-serial WIDTH-bit adder: one 8-bit carry-lookahead slice reused LSB-first,
// with valid/ready handshakes on both sides. Define SUB_EN to add the op_sub port (A-B).

module Carry_Look_Ahead_Adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       c8
);
    logic [7:0] p, g;
    logic [8:0] c;
    logic       pp;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of generate terms, not a ripple chain.
    always_comb begin
        c    = '0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end

    assign s  = p ^ c[7:0];
    assign c8 = c[8];
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CHUNKS = WIDTH / 8;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, next_state;
    logic [CHUNKS-1:0][7:0]  a_q, b_q, sum_q;
    logic [IDX_W-1:0]        idx;
    logic                    carry_q, cout_q;
    logic                    sub_q;
    logic [7:0]              a_byte, b_byte, s_byte;
    logic                    c8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) next_state = RUN;
            end
            RUN:  if (idx == LAST) next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef SUB_EN
    assign b_byte = b_q[idx] ^ {8{sub_q}};
`else
    assign b_byte = b_q[idx];
`endif
    assign a_byte = a_q[idx];

    Carry_Look_Ahead_Adder_8bit u_cla (
        .a   (a_byte),
        .b   (b_byte),
        .cin (carry_q),
        .s   (s_byte),
        .c8  (c8)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                    idx <= '0;
`ifdef SUB_EN
                    // Two's-complement subtract: invert B, inject +1 as the carry.
                    sub_q   <= op_sub;
                    carry_q <= op_sub ? 1'b1 : cin;
`else
                    sub_q   <= 1'b0;
                    carry_q <= cin;
`endif
                end
                RUN: begin
                    sum_q[idx] <= s_byte;
                    carry_q    <= c8;
                    if (idx == LAST) cout_q <= c8;
                    else             idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl (WIDTH=32): vector table, random sweep,
// backpressure, mid-operation reset, and subtract cases when SUB_EN is defined.

module tb_cla_seq_adder_ctrl;
    localparam int W      = 32;
    localparam int CHUNKS = W / 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;
    vec_t vecs[6];

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one accept; the expected result is computed here and queued.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                            input logic tsub);
        exp_t e;
        logic [W:0] full;
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        a = ta; b = tb_; cin = tcin; op_sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (tsub) full = {1'b0, ta} + {1'b0, ~tb_} + {{W{1'b0}}, 1'b1};
        else      full = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tcin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        sb.push_back(e);
    endtask

    // Count edges after the accept until out_valid, then compare with the scoreboard.
    task automatic finish_op(input string name);
        exp_t e;
        int cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!out_valid) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        chk({name, "_latency"}, cyc, CHUNKS);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({name, "_sum"}, sum, e.sum);
        chk({name, "_cout"}, cout, e.cout);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub);
        out_ready = 1'b1;
        start_op(ta, tb_, tcin, tsub);
        finish_op(name);
        @(posedge clk); #1;
        chk({name, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] hold_sum;
        logic         hold_cout;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h80808080, 32'h80808080, 1'b0, 32'h01010100, 1'b1};
        vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};

        // Reset state, held and after release
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_sum", sum, 0);

        // Table vectors: expected values are hand-derived constants
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            int   cyc = 0;
            out_ready = 1'b1;
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            void'(sb.pop_back());
            e.sum = vecs[i].sum; e.cout = vecs[i].cout;
            sb.push_back(e);
            chk($sformatf("vec%0d_busy", i), busy, 1);
            finish_op($sformatf("vec%0d", i));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_idle", i), in_ready, 1);
        end

        // Random sweep against the 33-bit model
        for (int i = 0; i < 10; i++)
            run_op($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

        // Backpressure: result held, new operands refused
        out_ready = 1'b0;
        start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        finish_op("bp");
        hold_sum = sum; hold_cout = cout;
        a = 32'hDEADBEEF; b = 32'h01020304; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_sum", i), sum, hold_sum);
            chk($sformatf("bp%0d_cout", i), cout, hold_cout);
            chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
            chk($sformatf("bp%0d_out_valid", i), out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_not_accepted_sum", sum, 32'h33333333);
        @(posedge clk); #1;
        chk("bp_no_accept_busy", busy, 0);

        // Reset two cycles into RUN aborts the operation
        out_ready = 1'b1;
        a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst%0d_out_valid", i), out_valid, 0);
        end
        run_op("post_rst_op", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        chk("post_rst_sum_abs", sum, 32'h00000100);
        chk("post_rst_cout_abs", cout, 0);

`ifdef SUB_EN
        run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 1'b1);
        chk("sub_borrow_abs", {cout, sum}, 33'h0FFFFFFFE);
        run_op("sub_noborrow", 32'h00000007, 32'h00000005, 1'b0, 1'b1);
        chk("sub_noborrow_abs", {cout, sum}, 33'h100000002);
        // cin set at accept and toggled throughout the run
        out_ready = 1'b1;
        start_op(32'h00000007, 32'h00000005, 1'b1, 1'b1);
        for (int i = 0; i < CHUNKS; i++) begin
            cin = ~cin;
            @(posedge clk); #1;
        end
        chk("sub_cin_valid", out_valid, 1);
        begin
            exp_t e;
            e = sb.pop_front();
            chk("sub_cin_sum", sum, e.sum);
            chk("sub_cin_cout", cout, e.cout);
        end
        @(posedge clk); #1;
        run_op("sub_op0_add", 32'h00000005, 32'h00000007, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
